myproject_mul_arb: RTL and testbench

MYPROJECT_MUL_ARB -- requirements
Module: myproject_mul_arb

---
 rtl/myproject_mul_arb.sv | 194 +++++++++++++++++++
 tb/tb_myproject_mul_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_arb.sv
// myproject_mul_arb: round-robin arbiter that shares one pipelined signed
// multiplier between NUM_REQ requesters. Results are returned in acceptance
// order through a small FIFO, and a credit check keeps that FIFO from
// overflowing.
module myproject_mul_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 13,
    parameter int DOUT_WIDTH = 26,
    parameter int MUL_STAGES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic                           busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold FIFO occupancy plus every pipeline stage.
    localparam int CW = $clog2(FIFO_DEPTH + MUL_STAGES + 1);

    // Arbitration state
    logic [ID_WIDTH-1:0]          ptr;
    logic                         grant_found;
    logic [ID_WIDTH-1:0]          grant_idx;
    logic [DIN_WIDTH-1:0]         sel_a;
    logic [DIN_WIDTH-1:0]         sel_b;
    logic                         credit;
    logic                         xfer;

    // Multiplier pipeline
    logic [MUL_STAGES-1:0]        vld;
    logic [ID_WIDTH-1:0]          id_q [MUL_STAGES];
    logic signed [DIN_WIDTH-1:0]  s1_a;
    logic signed [DIN_WIDTH-1:0]  s1_b;
    logic signed [DOUT_WIDTH-1:0] s1_prod;
    logic signed [DOUT_WIDTH-1:0] push_data;
    logic [CW-1:0]                inflight;

    // Result FIFO
    logic [DOUT_WIDTH-1:0]        data_mem [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]          id_mem   [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  occ;
    logic                         push;
    logic                         pop;

    // Count operations currently travelling through the multiplier stages.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < MUL_STAGES; k++) begin
            inflight = inflight + CW'(vld[k]);
        end
    end

    // A slot is free only if everything accepted and not yet popped still fits in the FIFO.
    assign credit = (CW'(occ) + inflight) < CW'(FIFO_DEPTH);

    // Round-robin search: indices ptr..NUM_REQ-1 first, then 0..ptr-1.
    // NOTE: every variable driven here gets a default at the top so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i >= int'(ptr))) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
                sel_a       = req_a[i*DIN_WIDTH +: DIN_WIDTH];
                sel_b       = req_b[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (i < int'(ptr))) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
                sel_a       = req_a[i*DIN_WIDTH +: DIN_WIDTH];
                sel_b       = req_b[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    // Reset gates the handshake so no requester sees a grant while the block is held in reset.
    assign xfer = grant_found & credit & ap_rst_n;

    // One-hot grant toward the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer && (grant_idx == ID_WIDTH'(i));
        end
    end

    // Advance the round-robin pointer past the requester that was just served.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pipeline valid bits shift one stage per cycle and never stall.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= xfer;
            for (int k = 1; k < MUL_STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    // Operand and id capture, qualified only by the valid bits above.
    // NOTE: datapath registers and FIFO storage are not reset; the valid bits and occupancy decide whether their contents mean anything.
    always_ff @(posedge ap_clk) begin
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        id_q[0]  <= grant_idx;
        for (int k = 1; k < MUL_STAGES; k++) begin
            id_q[k] <= id_q[k-1];
        end
    end

    // Sign-extend both operands before multiplying so the full product is kept.
    assign s1_prod = DOUT_WIDTH'(s1_a) * DOUT_WIDTH'(s1_b);

    if (MUL_STAGES == 1) begin : g_comb_out
        assign push_data = s1_prod;
    end else begin : g_prod_pipe
        logic signed [DOUT_WIDTH-1:0] prod_q [MUL_STAGES-1];

        // Product registers for stages 2..MUL_STAGES.
        always_ff @(posedge ap_clk) begin
            prod_q[0] <= s1_prod;
            for (int k = 1; k < MUL_STAGES - 1; k++) begin
                prod_q[k] <= prod_q[k-1];
            end
        end

        assign push_data = prod_q[MUL_STAGES-2];
    end

    assign push = vld[MUL_STAGES-1];
    assign pop  = rsp_valid & rsp_ready;

    // FIFO storage write; credit guarantees a free slot for every push.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            id_mem[wr_ptr]   <= id_q[MUL_STAGES-1];
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign rsp_valid = (occ != '0);
    // Gating with rsp_valid keeps the outputs at zero in and after reset, so stale storage is never exposed.
    assign rsp_data  = rsp_valid ? data_mem[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? id_mem[rd_ptr]   : '0;
    assign busy      = (inflight != '0) | rsp_valid;

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Testbench for myproject_mul_arb. The reference model keeps a queue of
// accepted operations. Each entry holds the product, the requester id and the
// cycle at which it becomes visible. The model's grant decision uses the
// round-robin and credit rules with plain integer arithmetic.
module tb_myproject_mul_arb;

    localparam int N  = 4;
    localparam int DW = 13;
    localparam int OW = 26;
    localparam int MS = 2;
    localparam int FD = 4;
    localparam int IW = 2;

    logic              ap_clk    = 1'b0;
    logic              ap_rst_n  = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a     = '0;
    logic [N*DW-1:0]   req_b     = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [OW-1:0]     rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              busy;

    myproject_mul_arb #(
        .NUM_REQ   (N),
        .DIN_WIDTH (DW),
        .DOUT_WIDTH(OW),
        .MUL_STAGES(MS),
        .FIFO_DEPTH(FD),
        .ID_WIDTH  (IW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int            id;
        logic [OW-1:0] prod;
        int            avail;
    } op_t;

    op_t           q[$];
    int            m_ptr;
    int            cyc;
    int            n_cmp;
    int            n_err;
    logic [DW-1:0] la [N];
    logic [DW-1:0] lb [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference product using plain integer arithmetic.
    function automatic logic [OW-1:0] mul_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int     sa;
        int     sb;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        p  = longint'(sa) * longint'(sb);
        return OW'(p);
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = la[i];
            req_b[i*DW +: DW] = lb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            la[i] = DW'($urandom);
            lb[i] = DW'($urandom);
        end
        pack_ops();
    endtask

    // One clock cycle: check the DUT outputs against the model, then update the model for the edge.
    task automatic step();
        int           g;
        int           idx;
        logic [N-1:0] exp_rdy;
        logic         head_v;
        @(negedge ap_clk);
        g = -1;
        if (q.size() < FD) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[IW'(idx)]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        head_v = (q.size() > 0) && (q[0].avail <= cyc);
        check("rsp_valid", 64'(rsp_valid), 64'(head_v));
        if (head_v) begin
            check("rsp_data", 64'(rsp_data), 64'(q[0].prod));
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
        end
        check("busy", 64'(busy), 64'(q.size() != 0));
        if (head_v && rsp_ready) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{g, mul_ref(la[IW'(g)], lb[IW'(g)]), cyc + MS + 1});
            m_ptr = (g + 1) % N;
        end
        @(posedge ap_clk);
        cyc++;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_data"},  64'(rsp_data),  64'(0));
        check({tag, "_rsp_id"},    64'(rsp_id),    64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ext_a [3];
        int ext_b [3];
        ext_a = '{-4096, -4096, 4095};
        ext_b = '{-4096,  4095, 4095};
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        m_ptr = 0;

        // Reset with every requester asking: nothing may be granted.
        ap_rst_n  = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        rand_ops();
        #12;
        check_reset_outputs("por");
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b1;
        req_valid = '0;

        // Single request: 3 * -5 from requester 0.
        la[0] = DW'(3);
        lb[0] = DW'(-5);
        pack_ops();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (6) step();

        // All requesters continuously valid: rotating grants at full rate.
        req_valid = '1;
        repeat (24) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Backpressure: credit must stop requester 2 after FIFO_DEPTH transfers.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        repeat (8) begin
            rand_ops();
            step();
        end
        rsp_ready = 1'b1;
        repeat (12) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Operand extremes from requester 1.
        for (int i = 0; i < 3; i++) begin
            la[1] = DW'(ext_a[i]);
            lb[1] = DW'(ext_b[i]);
            pack_ops();
            req_valid = 4'b0010;
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Reset mid-operation: two operations in flight and one buffered.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        repeat (3) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        #2;
        ap_rst_n  = 1'b0;
        req_valid = '1;
        #1;
        check_reset_outputs("mid_rst");
        q.delete();
        m_ptr = 0;
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        ap_rst_n  = 1'b1;
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        rand_ops();
        step();
        req_valid = '0;
        repeat (8) step();

        // Random traffic with random downstream stalls.
        repeat (1500) begin
            rand_ops();
            req_valid = N'($urandom);
            rsp_ready = $urandom_range(0, 1) == 1;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
